count_run_scheduler: RTL and testbench
======================================

Name: count_run_scheduler

Overview:
- Shares one 4-bit LED count datapath between N_REQ requesters, such as several debounced go buttons.
- Latches one pending request per requester and grants the datapath round-robin.
- Owns the tick divider and the count run.
- Drives the LED value and emits a per-requester done pulse; sits between the button debounce/edge-detect logic and the board LEDs.

Parameters:
- N_REQ, 2, number of requesters (≥2).
- CNT_W, 4, count/LED width.
- TICK_DIV, 3_000_000, clk cycles per count tick (≥2); 4 Hz at 12 MHz.

Ports:
- clk  input  1  system clock, 12 MHz on board.
- rst_btn  input  1  asynchronous active-low reset.
- req  input  N_REQ  single-cycle request pulses, already debounced and edge-detected; bit i = requester i.
- req_limit  input  N_REQ*CNT_W  per-requester final count; slice i = bits [i*CNT_W +: CNT_W]; sampled at grant only.
- abort  input  1  single-cycle pulse; cancels the current run.
- led  output  CNT_W  current count value.
- busy  output  1  high while the datapath is granted (state != IDLE).
- owner  output  clog2(N_REQ)  index of the granted requester; valid while busy.
- done  output  N_REQ  one-cycle pulse on the owner bit when its run completes.

Behaviour:
- Reset (rst_btn low, asynchronous): state=IDLE, led=0, busy=0, owner=0, done=0, pending=0, tick_cnt=0, last_grant=N_REQ-1, so requester 0 has first priority.
- Pending latches:
  - req[i]=1 sets pending[i] at the next edge.
  - A request while pending[i] is already set is absorbed; there is no queue depth beyond 1.
  - Set wins over a same-cycle clear by grant, so the request re-queues.
  - Requests are accepted in every state, including from the current owner.
- IDLE:
  - If any pending: grant the first set bit searching upward from last_grant+1, modulo N_REQ.
  - On grant: owner<=idx, limit_lat<=req_limit slice idx, pending[idx] cleared, led<=0, tick_cnt<=0, state<=RUN.
  - If none pending: led holds its last value.
- RUN:
  - tick_cnt counts 0..TICK_DIV-1 and wraps; a tick is the cycle with tick_cnt==TICK_DIV-1.
  - On a tick: if led==limit_lat, state<=DONE (led unchanged); else led<=led+1.
  - The count never wraps, because it stops at limit_lat ≤ 2^CNT_W-1.
  - Run length is exactly (limit_lat+1)*TICK_DIV cycles of RUN.
- DONE:
  - Lasts one cycle; done[owner]=1 during it; last_grant<=owner; state<=IDLE.
  - led holds the final value, which equals limit_lat.
  - busy stays high in DONE.
- abort:
  - In RUN, takes priority over a same-cycle tick: state<=IDLE, led<=0, no done, last_grant<=owner (fairness still advances).
  - In IDLE or DONE it is ignored.
- Latency:
  - A req pulse in cycle k with IDLE and no other pending gives pending at edge k+1, grant at edge k+2, busy high from cycle k+2.
  - Back-to-back runs: DONE → IDLE → grant costs 2 cycles between runs.
- Outputs are registered; done, led, busy and owner have no combinational path from inputs.
- Reset mid-run: everything returns to its reset values immediately; in-flight and pending runs are lost without a done pulse.

Test Plan:
1. TICK_DIV=4. req[0] pulse with limit0=3. Required: busy high 2 cycles later, owner=0; led steps 0→1→2→3 at ticks 1–3; done[0] pulses once after 16 RUN cycles; led stays 3; busy low one cycle after done.
2. After reset, req=2'b11 in the same cycle with limits 1 and 2. Required: requester 0 runs first (8 RUN cycles, done[0]), then requester 1 (12 RUN cycles, done[1]); never two done bits at once.
3. Round-robin: run requester 1 alone, then pulse req=2'b11. Required: requester 0 granted first; after it completes and both are pending again, requester 1 is granted.
4. abort in RUN when led=2, with req[1] pending. Required: next cycle state IDLE, led=0, no done[0] ever; requester 1 granted one cycle later. Also: abort in the same cycle as the final tick produces no done.
5. Boundaries:
   - limit=0: done after exactly TICK_DIV RUN cycles, led=0 throughout.
   - limit=15: led reaches 15 and holds it, no wrap to 0.
   - req[0] pulsed twice during its own run: exactly one extra run follows.
6. Drive rst_btn low mid-run at led=5 with req[1] pending. Required: led, busy and done go to 0 immediately, asynchronously, without a clock edge; after release no grant occurs until a new req arrives; requester 0 has priority on the next simultaneous request.

Source files
------------

// File: rtl/count_run_scheduler.sv
// Round-robin arbiter sharing one tick-driven LED count datapath
// between several requesters, with per-requester done pulses.
module count_run_scheduler #(
    parameter int N_REQ    = 2,
    parameter int CNT_W    = 4,
    parameter int TICK_DIV = 3_000_000,
    localparam int OW      = (N_REQ > 1) ? $clog2(N_REQ) : 1,
    localparam int TW      = $clog2(TICK_DIV)
) (
    input  logic                   clk,
    input  logic                   rst_btn,
    input  logic [N_REQ-1:0]       req,
    input  logic [N_REQ*CNT_W-1:0] req_limit,
    input  logic                   abort,
    output logic [CNT_W-1:0]       led,
    output logic                   busy,
    output logic [OW-1:0]          owner,
    output logic [N_REQ-1:0]       done
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] led_q, led_n;
    logic [CNT_W-1:0] lim_q, lim_n;
    logic [OW-1:0]    owner_q, owner_n;
    logic [OW-1:0]    last_q, last_n;
    logic [TW-1:0]    tick_q, tick_n;
    logic [N_REQ-1:0] pend_q, pend_n;

    logic             grant_vld;
    logic [OW-1:0]    grant_idx;
    logic             tick;
    int               j;

    // First pending bit at or after last_grant+1, wrapping.
    always_comb begin
        grant_vld = 1'b0;
        grant_idx = '0;
        j         = 0;
        for (int k = 1; k <= N_REQ; k++) begin
            j = (int'(last_q) + k) % N_REQ;
            if (!grant_vld && pend_q[j]) begin
                grant_vld = 1'b1;
                grant_idx = OW'(j);
            end
        end
    end

    assign tick = (tick_q == TW'(TICK_DIV - 1));

    always_comb begin
        state_n = state;
        led_n   = led_q;
        lim_n   = lim_q;
        owner_n = owner_q;
        last_n  = last_q;
        tick_n  = tick_q;
        pend_n  = pend_q;
        unique case (state)
            IDLE: begin
                if (grant_vld) begin
                    owner_n           = grant_idx;
                    lim_n             = req_limit[grant_idx*CNT_W +: CNT_W];
                    pend_n[grant_idx] = 1'b0;
                    led_n             = '0;
                    tick_n            = '0;
                    state_n           = RUN;
                end
            end
            RUN: begin
                if (abort) begin
                    state_n = IDLE;
                    led_n   = '0;
                    tick_n  = '0;
                    last_n  = owner_q;
                end else begin
                    tick_n = tick ? '0 : tick_q + TW'(1);
                    if (tick) begin
                        if (led_q == lim_q) state_n = DONE;
                        else led_n = led_q + CNT_W'(1);
                    end
                end
            end
            DONE: begin
                last_n  = owner_q;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // A new request beats the clear from a same-cycle grant.
        pend_n = pend_n | req;
    end

    always_ff @(posedge clk or negedge rst_btn) begin
        if (!rst_btn) begin
            state   <= IDLE;
            led_q   <= '0;
            lim_q   <= '0;
            owner_q <= '0;
            last_q  <= OW'(N_REQ - 1);
            tick_q  <= '0;
            pend_q  <= '0;
        end else begin
            state   <= state_n;
            led_q   <= led_n;
            lim_q   <= lim_n;
            owner_q <= owner_n;
            last_q  <= last_n;
            tick_q  <= tick_n;
            pend_q  <= pend_n;
        end
    end

    assign led   = led_q;
    assign busy  = (state != IDLE);
    assign owner = owner_q;
    assign done  = (state == DONE) ? (N_REQ'(1) << owner_q) : '0;

endmodule

// File: tb/tb_count_run_scheduler.sv
// Scoreboard bench for count_run_scheduler: arbitration order, run
// length, abort, boundaries and asynchronous reset.
module tb_count_run_scheduler;

    localparam int N_REQ = 2;
    localparam int CNT_W = 4;
    localparam int TD    = 4;

    logic       clk = 1'b0;
    logic       rst_btn = 1'b0;
    logic [1:0] req = '0;
    logic [7:0] req_limit = '0;
    logic       abort = 1'b0;
    logic [3:0] led;
    logic       busy;
    logic       owner;
    logic [1:0] done;

    always #5 clk = ~clk;

    count_run_scheduler #(
        .N_REQ(N_REQ),
        .CNT_W(CNT_W),
        .TICK_DIV(TD)
    ) dut (
        .clk(clk),
        .rst_btn(rst_btn),
        .req(req),
        .req_limit(req_limit),
        .abort(abort),
        .led(led),
        .busy(busy),
        .owner(owner),
        .done(done)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    typedef struct {
        int idx;
        int lim;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;

    task automatic push(input int idx, input int lim);
        exp_t e;
        e.idx = idx;
        e.lim = lim;
        sb.push_back(e);
    endtask

    int         run_cnt = 0;
    logic       prev_busy = 1'b0;
    logic [3:0] prev_led = '0;

    always @(negedge clk) begin
        if (rst_btn) begin
            if (done != 2'b00) begin
                if (sb.size() == 0) begin
                    chk("unexp_done", {30'b0, done}, 0);
                end else begin
                    mon_e = sb.pop_front();
                    chk("done_bits", {30'b0, done}, 1 << mon_e.idx);
                    chk("done_owner", {31'b0, owner}, mon_e.idx);
                    chk("done_led", {28'b0, led}, mon_e.lim);
                    chk("run_len", run_cnt, (mon_e.lim + 1) * TD);
                end
                run_cnt = 0;
            end else if (busy) begin
                run_cnt++;
            end else begin
                run_cnt = 0;
            end
            if (busy && prev_busy && led != prev_led)
                chk("led_step", {28'b0, led}, prev_led + 1);
            if (busy && sb.size() > 0 && int'(owner) == sb[0].idx)
                chk("led_le_lim", {31'b0, int'(led) <= sb[0].lim}, 1);
        end else begin
            run_cnt = 0;
        end
        prev_busy = busy;
        prev_led  = led;
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [1:0] m);
        req = m;
        cyc(1);
        req = '0;
    endtask

    task automatic wait_done(input int budget, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (done != 2'b00) seen = 1'b1;
        end
        chk(tag, {31'b0, seen}, 1);
        cyc(1);
    endtask

    task automatic wait_busy(input int budget, input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
        end
        chk(tag, {31'b0, seen}, 1);
    endtask

    task automatic wait_led(input logic [3:0] v, input int budget,
                            input string tag);
        bit seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (led == v) seen = 1'b1;
        end
        chk(tag, {31'b0, seen}, 1);
    endtask

    task automatic do_reset();
        rst_btn = 1'b0;
        req     = '0;
        abort   = 1'b0;
        cyc(2);
        chk("rst_led", {28'b0, led}, 0);
        chk("rst_busy", {31'b0, busy}, 0);
        chk("rst_owner", {31'b0, owner}, 0);
        chk("rst_done", {30'b0, done}, 0);
        sb.delete();
        rst_btn = 1'b1;
        cyc(1);
    endtask

    int ndone;

    initial begin
        do_reset();

        // single run, limit 3
        req_limit = {4'd0, 4'd3};
        push(0, 3);
        pulse(2'b01);
        chk("t1_busy_pre", {31'b0, busy}, 0);
        cyc(1);
        chk("t1_busy", {31'b0, busy}, 1);
        chk("t1_owner", {31'b0, owner}, 0);
        chk("t1_led0", {28'b0, led}, 0);
        wait_done(40, "t1_done");
        chk("t1_busy_post", {31'b0, busy}, 0);
        chk("t1_led_post", {28'b0, led}, 3);
        cyc(3);
        chk("t1_led_hold", {28'b0, led}, 3);

        // simultaneous requests after reset
        do_reset();
        req_limit = {4'd2, 4'd1};
        push(0, 1);
        push(1, 2);
        pulse(2'b11);
        wait_done(40, "t2_done0");
        wait_done(40, "t2_done1");

        // round-robin rotation
        do_reset();
        req_limit = {4'd1, 4'd2};
        push(1, 1);
        pulse(2'b10);
        wait_done(40, "t3_done1");
        push(0, 2);
        pulse(2'b11);
        wait_busy(10, "t3_busy");
        chk("t3_owner0", {31'b0, owner}, 0);
        push(1, 1);
        push(0, 2);
        pulse(2'b01);
        wait_done(40, "t3_done_a");
        cyc(1);
        chk("t3_rr_owner", {31'b0, owner}, 1);
        wait_done(40, "t3_done_b");
        wait_done(40, "t3_done_c");

        // abort at led=2 with requester 1 pending
        do_reset();
        req_limit = {4'd1, 4'd5};
        pulse(2'b01);
        wait_busy(10, "t4_busy");
        push(1, 1);
        pulse(2'b10);
        wait_led(4'd2, 40, "t4_led2");
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("t4_ab_busy", {31'b0, busy}, 0);
        chk("t4_ab_led", {28'b0, led}, 0);
        chk("t4_ab_done", {30'b0, done}, 0);
        cyc(1);
        chk("t4_gr_busy", {31'b0, busy}, 1);
        chk("t4_gr_owner", {31'b0, owner}, 1);
        wait_done(40, "t4_done1");

        // abort coinciding with the final tick
        req_limit = {4'd1, 4'd0};
        pulse(2'b01);
        wait_busy(10, "t4b_busy");
        repeat (3) @(posedge clk);
        #1;
        abort = 1'b1;
        @(posedge clk);
        #1;
        abort = 1'b0;
        chk("t4b_busy", {31'b0, busy}, 0);
        chk("t4b_led", {28'b0, led}, 0);
        ndone = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (done != 2'b00) ndone++;
        end
        chk("t4b_no_done", ndone, 0);
        cyc(1);

        // limit 0
        req_limit = {4'd0, 4'd0};
        push(0, 0);
        pulse(2'b01);
        wait_done(20, "t5_done_l0");

        // limit 15, no wrap
        req_limit = {4'd0, 4'd15};
        push(0, 15);
        pulse(2'b01);
        wait_done(100, "t5_done_l15");
        chk("t5_led15", {28'b0, led}, 15);
        cyc(3);
        chk("t5_led15_hold", {28'b0, led}, 15);

        // owner re-requests twice during its own run
        req_limit = {4'd0, 4'd1};
        push(0, 1);
        pulse(2'b01);
        wait_busy(10, "t5_busy");
        pulse(2'b01);
        cyc(1);
        pulse(2'b01);
        push(0, 1);
        wait_done(40, "t5_done_r1");
        wait_done(40, "t5_done_r2");
        cyc(20);
        chk("t5_idle", {31'b0, busy}, 0);
        chk("t5_sb_empty", sb.size(), 0);

        // asynchronous reset mid-run
        do_reset();
        req_limit = {4'd1, 4'd9};
        pulse(2'b01);
        wait_busy(10, "t6_busy");
        pulse(2'b10);
        wait_led(4'd5, 60, "t6_led5");
        #2;
        rst_btn = 1'b0;
        #1;
        chk("t6_led", {28'b0, led}, 0);
        chk("t6_busy", {31'b0, busy}, 0);
        chk("t6_done", {30'b0, done}, 0);
        cyc(2);
        rst_btn = 1'b1;
        cyc(20);
        chk("t6_no_grant", {31'b0, busy}, 0);
        req_limit = {4'd1, 4'd2};
        push(0, 2);
        push(1, 1);
        pulse(2'b11);
        cyc(1);
        chk("t6_gr_busy", {31'b0, busy}, 1);
        chk("t6_gr_owner", {31'b0, owner}, 0);
        wait_done(40, "t6_done0");
        wait_done(40, "t6_done1");
        chk("end_sb_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
